// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with a req/ack data port, a wait-state
// timeout, and the MEM/WB register that also serves as the MEMWB forwarding source.
//   clock, reset_n                 clock, asynchronous active-low reset
//   in_*                           EX/MEM register contents (held while stall=1)
//   stall                          freezes EX/MEM and all earlier stages
//   dmem_req/we/addr/be/wdata      data-memory request (word address, byte lanes)
//   dmem_ack/rdata                 completion strobe and read data
//   wb_*                           MEM/WB register (wb_exc: bit0 misaligned, bit1 bus error)
module mem_stage #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [1:0]  in_size,
    input  logic        in_load_u,
    input  logic [4:0]  in_dest_reg,
    input  logic        in_dest_reg_valid,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_dest_reg,
    output logic        wb_dest_reg_valid,
    output logic [1:0]  wb_exc
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             mem_op, aligned, is_byte, is_half, timeout, ack_ok;
    logic [1:0]       exc;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_val;

    assign is_byte = in_size == 2'b00;
    assign is_half = in_size == 2'b01;
    assign mem_op  = in_valid & (in_load | in_store);
    assign aligned = is_byte | (is_half & ~in_result[0]) | (~is_byte & ~is_half & in_result[1:0] == 2'b00);
    assign timeout = state == WAIT && cnt == CNT_W'(TIMEOUT);
    // Gated by reset_n so the request drops the instant reset is asserted.
    assign dmem_req   = reset_n & mem_op & aligned & ~timeout;
    assign dmem_we    = dmem_req & in_store;
    assign ack_ok     = dmem_req & dmem_ack;
    assign stall      = dmem_req & ~dmem_ack;
    assign exc        = {timeout, mem_op & ~aligned};
    assign dmem_addr  = {in_result[31:2], 2'b00};
    assign dmem_be    = is_byte ? 4'b0001 << in_result[1:0] : is_half ? (in_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign dmem_wdata = is_byte ? {4{in_store_data[7:0]}} : is_half ? {2{in_store_data[15:0]}} : in_store_data;
    assign ld_b       = dmem_rdata[{in_result[1:0], 3'b000} +: 8];
    assign ld_h       = in_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign ld_val     = is_byte ? {{24{~in_load_u & ld_b[7]}}, ld_b} : is_half ? {{16{~in_load_u & ld_h[15]}}, ld_h} : dmem_rdata;

    // WAIT is left whenever the stage stops stalling: ack, timeout, or a lost request.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (stall) begin
                state_nx = WAIT;
                cnt_nx   = CNT_W'(1);
            end
        end else if (!stall) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            cnt_nx = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            wb_valid          <= 1'b0;
            wb_result         <= '0;
            wb_dest_reg       <= '0;
            wb_dest_reg_valid <= 1'b0;
            wb_exc            <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (stall) begin
                wb_valid          <= 1'b0;
                wb_dest_reg_valid <= 1'b0;
                wb_exc            <= '0;
            end else begin
                wb_valid          <= in_valid;
                wb_dest_reg       <= in_dest_reg;
                wb_result         <= (in_load & ack_ok) ? ld_val : in_result;
                wb_dest_reg_valid <= in_valid & in_dest_reg_valid & ~in_store & ~|exc;
                wb_exc            <= exc;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand-written multi-cycle sequences for mem_stage.
module tb_mem_stage;
    localparam int TIMEOUT = 64;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_load = 1'b0, in_store = 1'b0, in_load_u = 1'b0, in_dest_reg_valid = 1'b0;
    logic [31:0] in_result = '0, in_store_data = '0, dmem_rdata = '0;
    logic [1:0]  in_size = '0;
    logic [4:0]  in_dest_reg = '0;
    logic        dmem_ack = 1'b0;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_dest_reg_valid;
    logic [31:0] dmem_addr, dmem_wdata, wb_result;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_dest_reg;
    logic [1:0]  wb_exc;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_result(in_result),
        .in_store_data(in_store_data), .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_load_u(in_load_u), .in_dest_reg(in_dest_reg), .in_dest_reg_valid(in_dest_reg_valid),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_dest_reg(wb_dest_reg),
        .wb_dest_reg_valid(wb_dest_reg_valid), .wb_exc(wb_exc)
    );

    typedef struct {
        logic        v, ld, st, u, ack, dv;
        logic [1:0]  sz;
        logic [31:0] res, sd, rd;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_wv;
        logic [31:0] e_wres;
        logic        e_wdv;
        logic [1:0]  e_exc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic v, logic ld, logic st, logic [1:0] sz, logic u, logic [31:0] res,
                                logic [31:0] sd, logic ack, logic [31:0] rd, logic dv,
                                logic e_req, logic e_we, logic [3:0] e_be, logic [31:0] e_wd,
                                logic e_wv, logic [31:0] e_wres, logic e_wdv, logic [1:0] e_exc);
        vec_t t;
        t.v = v; t.ld = ld; t.st = st; t.sz = sz; t.u = u; t.res = res; t.sd = sd; t.ack = ack;
        t.rd = rd; t.dv = dv; t.e_req = e_req; t.e_we = e_we; t.e_be = e_be; t.e_wd = e_wd;
        t.e_wv = e_wv; t.e_wres = e_wres; t.e_wdv = e_wdv; t.e_exc = e_exc;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz, input logic u,
                         input logic [31:0] res, input logic [31:0] sd, input logic [4:0] dst, input logic dv,
                         input logic ack, input logic [31:0] rd);
        in_valid = v; in_load = ld; in_store = st; in_size = sz; in_load_u = u; in_result = res;
        in_store_data = sd; in_dest_reg = dst; in_dest_reg_valid = dv; dmem_ack = ack; dmem_rdata = rd;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        add(1,0,0,2'd2,0,32'h12345678,32'h0,1,32'hFFFFFFFF,1, 0,0,4'h0,32'h0, 1,32'h12345678,1,2'd0);
        add(1,1,0,2'd0,0,32'h00000103,32'h0,1,32'h80FF0000,1, 1,0,4'b1000,32'h0, 1,32'hFFFFFF80,1,2'd0);
        add(1,1,0,2'd0,1,32'h00000103,32'h0,1,32'h80FF0000,1, 1,0,4'b1000,32'h0, 1,32'h00000080,1,2'd0);
        add(1,1,0,2'd1,0,32'h00000102,32'h0,1,32'h80017FFF,1, 1,0,4'b1100,32'h0, 1,32'hFFFF8001,1,2'd0);
        add(1,1,0,2'd1,1,32'h00000100,32'h0,1,32'h8001FFFF,1, 1,0,4'b0011,32'h0, 1,32'h0000FFFF,1,2'd0);
        add(1,1,0,2'd2,0,32'h00000040,32'h0,1,32'hDEADBEEF,1, 1,0,4'b1111,32'h0, 1,32'hDEADBEEF,1,2'd0);
        add(1,0,1,2'd0,0,32'h00000201,32'h123456A5,1,32'h0,1, 1,1,4'b0010,32'hA5A5A5A5, 1,32'h00000201,0,2'd0);
        add(1,0,1,2'd2,0,32'h00000300,32'hCAFEF00D,1,32'h0,1, 1,1,4'b1111,32'hCAFEF00D, 1,32'h00000300,0,2'd0);
        add(1,1,0,2'd2,0,32'h00000101,32'h0,1,32'h0,1, 0,0,4'h0,32'h0, 1,32'h00000101,0,2'd1);
        add(1,0,1,2'd1,0,32'h00000203,32'h0,1,32'h0,1, 0,0,4'h0,32'h0, 1,32'h00000203,0,2'd1);
        add(0,1,0,2'd2,0,32'h00000055,32'h0,0,32'h0,1, 0,0,4'h0,32'h0, 0,32'h00000055,0,2'd0);
        add(1,1,0,2'd3,0,32'h00000008,32'h0,1,32'h01020304,1, 1,0,4'b1111,32'h0, 1,32'h01020304,1,2'd0);
        add(1,1,0,2'd0,0,32'h00000101,32'h0,1,32'h00007F00,1, 1,0,4'b0010,32'h0, 1,32'h0000007F,1,2'd0);
        add(1,1,0,2'd3,0,32'h00000102,32'h0,1,32'h0,1, 0,0,4'h0,32'h0, 1,32'h00000102,0,2'd1);

        // Reset state
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_result", wb_result, 0);
        chk("rst_wb_dest", wb_dest_reg, 0);
        chk("rst_wb_dv", wb_dest_reg_valid, 0);
        chk("rst_wb_exc", wb_exc, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Single-cycle vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v, vecs[i].ld, vecs[i].st, vecs[i].sz, vecs[i].u, vecs[i].res, vecs[i].sd,
                  5'(i + 1), vecs[i].dv, vecs[i].ack, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_stall", i), stall, 0);
            chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
            chk($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_addr", i), dmem_addr, {vecs[i].res[31:2], 2'b00});
                chk($sformatf("v%0d_be", i), dmem_be, vecs[i].e_be);
                chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wd);
            end
            tick();
            chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].e_wv);
            chk($sformatf("v%0d_wb_result", i), wb_result, vecs[i].e_wres);
            chk($sformatf("v%0d_wb_dv", i), wb_dest_reg_valid, vecs[i].e_wdv);
            chk($sformatf("v%0d_wb_exc", i), wb_exc, vecs[i].e_exc);
            if (vecs[i].v) chk($sformatf("v%0d_wb_dest", i), wb_dest_reg, 5'(i + 1));
        end

        // sh with 3 wait states, then a back-to-back load
        drive(1,0,1,2'd1,0,32'h00000202,32'hABCD1234,5'd7,1,0,32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sh_stall", stall, 1);
            chk("sh_req", dmem_req, 1);
            chk("sh_we", dmem_we, 1);
            chk("sh_addr", dmem_addr, 32'h200);
            chk("sh_be", dmem_be, 4'b1100);
            chk("sh_wdata", dmem_wdata, 32'h12341234);
            tick();
            chk("sh_bubble_valid", wb_valid, 0);
            chk("sh_bubble_dv", wb_dest_reg_valid, 0);
        end
        dmem_ack = 1'b1;
        #1;
        chk("sh_ack_stall", stall, 0);
        chk("sh_ack_req", dmem_req, 1);
        tick();
        chk("sh_wb_valid", wb_valid, 1);
        chk("sh_wb_result", wb_result, 32'h202);
        chk("sh_wb_dv", wb_dest_reg_valid, 0);
        chk("sh_wb_exc", wb_exc, 0);
        drive(1,1,0,2'd2,0,32'h00000044,32'h0,5'd9,1,1,32'h55AA55AA);
        #1;
        chk("b2b_req", dmem_req, 1);
        chk("b2b_stall", stall, 0);
        tick();
        chk("b2b_wb_result", wb_result, 32'h55AA55AA);
        chk("b2b_wb_dv", wb_dest_reg_valid, 1);

        // Timeout: lw with no ack ever
        drive(1,1,0,2'd2,0,32'h00000040,32'h0,5'd3,1,0,32'h0);
        n = 0;
        #1;
        while (stall && n < TIMEOUT + 4) begin
            n++;
            @(posedge clock);
            #2;
        end
        chk("to_stall_cycles", n, TIMEOUT);
        chk("to_req_dropped", dmem_req, 0);
        chk("to_stall_low", stall, 0);
        tick();
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_exc", wb_exc, 2'b10);
        chk("to_wb_dv", wb_dest_reg_valid, 0);
        drive(1,0,0,2'd2,0,32'h00000777,32'h0,5'd4,1,0,32'h0);
        #1;
        chk("to_next_stall", stall, 0);
        tick();
        chk("to_next_result", wb_result, 32'h777);
        chk("to_next_dv", wb_dest_reg_valid, 1);
        chk("to_next_exc", wb_exc, 0);

        // Reset while waiting, then a normal load
        drive(1,1,0,2'd2,0,32'h00000040,32'h0,5'd6,1,0,32'h0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("rw_req", dmem_req, 0);
        chk("rw_stall", stall, 0);
        chk("rw_wb_valid", wb_valid, 0);
        chk("rw_wb_result", wb_result, 0);
        chk("rw_wb_dest", wb_dest_reg, 0);
        tick();
        reset_n = 1'b1;
        drive(1,1,0,2'd2,0,32'h00000080,32'h0,5'd6,1,1,32'h0BADF00D);
        #1;
        chk("rw_lw_req", dmem_req, 1);
        chk("rw_lw_stall", stall, 0);
        tick();
        chk("rw_lw_result", wb_result, 32'h0BADF00D);
        chk("rw_lw_valid", wb_valid, 1);
        chk("rw_lw_exc", wb_exc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
